ball_pool: RTL and testbench

- Boss projectile manager: a pool of NUM_BALLS independent ball slots, each with its own lifetime counter. The pool can also hold several overlapping volleys at once.
- On a fire request, a spawner FSM launches a volley pattern from the boss position, aimed at the kid.
- Each frame the block reports pixel coverage (isBall, ball_id) to the colour mapper and kid collision (hitBall) to game control.
- New over the previous generation: parametrised pool, selectable patterns, free-slot allocation, cooldown, off-screen culling and kill-on-hit.

---
 rtl/ball_pkg.sv | 63 ++++++
 rtl/ball_if.sv | 30 +++
 rtl/ball_slot.sv | 90 +++++++++
 rtl/ball_pool.sv | 168 ++++++++++++++++
 tb/tb_ball_pool.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared types and lookup helpers for the boss projectile pool.
//   pattern_t       - volley pattern select (RSVD behaves as SINGLE)
//   slot_state_t    - per-slot lifecycle
//   spawner_state_t - spawner FSM encoding
//   lane_count()    - number of lanes launched by a pattern
//   vel()           - base (dx, dy) for a pattern lane, before aiming
package ball_pkg;

    typedef enum logic [1:0] {FAN5 = 2'd0, RING8 = 2'd1, SINGLE = 2'd2, RSVD = 2'd3} pattern_t;
    typedef enum logic {FREE = 1'b0, ALIVE = 1'b1} slot_state_t;
    typedef enum logic [1:0] {IDLE = 2'd0, SPAWN = 2'd1, COOL = 2'd2} spawner_state_t;

    typedef struct packed {
        logic signed [9:0] dx;
        logic signed [9:0] dy;
    } vel_t;

    function automatic logic [3:0] lane_count(pattern_t p);
        case (p)
            FAN5:    return 4'd5;
            RING8:   return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic vel_t mk(int dx, int dy);
        vel_t v;
        v.dx = 10'(dx);
        v.dy = 10'(dy);
        return v;
    endfunction

    // Slow fan and ring so whole volleys stay on screen for most of their
    // lifetime; the single shot is the fast aimed one.
    function automatic vel_t vel(pattern_t p, logic [2:0] lane);
        case (p)
            FAN5: begin
                case (lane)
                    3'd0:    return mk(0, -1);
                    3'd1:    return mk(-1, -1);
                    3'd2:    return mk(1, -1);
                    3'd3:    return mk(-1, 0);
                    3'd4:    return mk(1, 0);
                    default: return mk(0, 0);
                endcase
            end
            RING8: begin
                case (lane)
                    3'd0:    return mk(1, 0);
                    3'd1:    return mk(1, 1);
                    3'd2:    return mk(0, 1);
                    3'd3:    return mk(-1, 1);
                    3'd4:    return mk(-1, 0);
                    3'd5:    return mk(-1, -1);
                    3'd6:    return mk(0, -1);
                    default: return mk(1, -1);
                endcase
            end
            default: return mk(-4, -10);
        endcase
    endfunction

endpackage

// File: rtl/ball_if.sv
// ball_if: frame-level bus between game logic and the projectile pool.
//   master: drives fire/pattern, boss/kid positions, current pixel
//   slave : returns isBall/ball_id, hitBall, ready, active_count, dropped
interface ball_if #(parameter int NUM_BALLS = 8);
    localparam int IDW = $clog2(NUM_BALLS);

    logic           fire;
    logic [1:0]     pattern;
    logic [9:0]     Boss_position_X, Boss_position_Y;
    logic [9:0]     Kid_position_X, Kid_position_Y;
    logic [9:0]     DrawX, DrawY;
    logic           isBall;
    logic [IDW-1:0] ball_id;
    logic           hitBall;
    logic           ready;
    logic [IDW:0]   active_count;
    logic           dropped;

    modport master (
        output fire, pattern, Boss_position_X, Boss_position_Y,
               Kid_position_X, Kid_position_Y, DrawX, DrawY,
        input  isBall, ball_id, hitBall, ready, active_count, dropped
    );

    modport slave (
        input  fire, pattern, Boss_position_X, Boss_position_Y,
               Kid_position_X, Kid_position_Y, DrawX, DrawY,
        output isBall, ball_id, hitBall, ready, active_count, dropped
    );
endinterface

// File: rtl/ball_slot.sv
// ball_slot: one projectile slot (position, velocity, lifetime).
//   i_spawn            - load position/velocity and go ALIVE this edge
//   i_spawn_x/y, i_dx/dy - spawn origin and per-frame motion
//   i_kid_x/y          - kid box top-left; i_draw_x/y - current pixel
//   o_keep             - alive and staying alive through this edge
//   o_covers, o_hit    - pixel coverage and kid overlap (combinational)
module ball_slot
    import ball_pkg::*;
#(
    parameter int LIFETIME    = 300,
    parameter int RADIUS      = 10,
    parameter int KID_SIZE    = 32,
    parameter int KILL_ON_HIT = 1,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    input  logic              i_spawn,
    input  logic [9:0]        i_spawn_x,
    input  logic [9:0]        i_spawn_y,
    input  logic signed [9:0] i_dx,
    input  logic signed [9:0] i_dy,
    input  logic [9:0]        i_kid_x,
    input  logic [9:0]        i_kid_y,
    input  logic [9:0]        i_draw_x,
    input  logic [9:0]        i_draw_y,
    output logic              o_keep,
    output logic              o_covers,
    output logic              o_hit
);
    localparam int LW = $clog2(LIFETIME + 1);
    localparam logic signed [10:0] XM = 11'(X_MAX);
    localparam logic signed [10:0] YM = 11'(Y_MAX);

    slot_state_t       r_state;
    logic [9:0]        r_x, r_y;
    logic signed [9:0] r_dx, r_dy;
    logic [LW-1:0]     r_life;

    logic              w_alive;
    logic signed [10:0] w_nx, w_ny;
    logic              w_cull;
    logic signed [31:0] w_cx, w_cy, w_kx, w_ky, w_ddx, w_ddy;

    assign w_alive = (r_state == ALIVE);
    assign w_nx    = $signed({1'b0, r_x}) + $signed({r_dx[9], r_dx});
    assign w_ny    = $signed({1'b0, r_y}) + $signed({r_dy[9], r_dy});
    assign w_cull  = (w_nx < 0) || (w_nx > XM) || (w_ny < 0) || (w_ny > YM);

    // Expiry, cull and kill all collapse into a single "not kept".
    assign o_keep = w_alive && (r_life != '0) && !w_cull &&
                    !((KILL_ON_HIT != 0) && o_hit);

    assign w_cx  = $signed({22'd0, r_x});
    assign w_cy  = $signed({22'd0, r_y});
    assign w_kx  = $signed({22'd0, i_kid_x});
    assign w_ky  = $signed({22'd0, i_kid_y});
    assign w_ddx = $signed({22'd0, i_draw_x}) - w_cx;
    assign w_ddy = $signed({22'd0, i_draw_y}) - w_cy;

    assign o_covers = w_alive && ((w_ddx * w_ddx + w_ddy * w_ddy) <= RADIUS * RADIUS);
    assign o_hit    = w_alive &&
                      (w_cx - RADIUS <= w_kx + KID_SIZE) && (w_cx + RADIUS >= w_kx) &&
                      (w_cy - RADIUS <= w_ky + KID_SIZE) && (w_cy + RADIUS >= w_ky);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= FREE;
            r_x     <= '0;
            r_y     <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_life  <= '0;
        end else if (i_spawn) begin
            r_state <= ALIVE;
            r_x     <= i_spawn_x;
            r_y     <= i_spawn_y;
            r_dx    <= i_dx;
            r_dy    <= i_dy;
            r_life  <= LW'(LIFETIME - 1);
        end else if (o_keep) begin
            r_x     <= w_nx[9:0];
            r_y     <= w_ny[9:0];
            r_life  <= r_life - LW'(1);
        end else begin
            r_state <= FREE;
        end
    end
endmodule

// File: rtl/ball_pool.sv
// ball_pool: boss projectile manager with a volley spawner.
//   frame_clk, Reset_n - frame clock, async active-low reset
//   bus (ball_if.slave) - fire/pattern/positions/pixel in;
//                         isBall, ball_id, hitBall, ready, active_count, dropped out
//
// state | meaning
// IDLE  | ready; fire latches pattern and positions
// SPAWN | one frame: lanes allocated to free slots
// COOL  | cooldown countdown, fire ignored
module ball_pool
    import ball_pkg::*;
#(
    parameter int NUM_BALLS   = 8,
    parameter int LIFETIME    = 300,
    parameter int RADIUS      = 10,
    parameter int KID_SIZE    = 32,
    parameter int COOLDOWN    = 60,
    parameter int KILL_ON_HIT = 1,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input logic  frame_clk,
    input logic  Reset_n,
    ball_if.slave bus
);
    localparam int IDW = $clog2(NUM_BALLS);
    localparam int CW  = IDW + 1;
    localparam int CDW = $clog2(COOLDOWN + 1);

    spawner_state_t r_state, w_state_nxt;
    logic [CDW-1:0] r_cool;
    pattern_t       r_pat;
    logic [9:0]     r_bx, r_by, r_kx, r_ky;

    logic                 w_negx, w_negy, w_short;
    logic [4:0]           w_lanes, w_n, w_free;
    logic [NUM_BALLS-1:0] w_keep, w_covers, w_hit, w_spawn;
    logic [2:0]           w_lane [NUM_BALLS];
    logic signed [9:0]    w_sdx [NUM_BALLS];
    logic signed [9:0]    w_sdy [NUM_BALLS];
    logic [IDW-1:0]       w_id;
    logic [CW-1:0]        w_active_nxt, r_active;
    logic                 r_hit, r_dropped;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cool  <= '0;
            r_pat   <= SINGLE;
            r_bx    <= '0;
            r_by    <= '0;
            r_kx    <= '0;
            r_ky    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (bus.fire) begin
                    r_pat <= pattern_t'(bus.pattern);
                    r_bx  <= bus.Boss_position_X;
                    r_by  <= bus.Boss_position_Y;
                    r_kx  <= bus.Kid_position_X;
                    r_ky  <= bus.Kid_position_Y;
                end
                SPAWN:   r_cool <= CDW'(COOLDOWN - 1);
                COOL:    if (r_cool != '0) r_cool <= r_cool - CDW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.fire) w_state_nxt = SPAWN;
            SPAWN:   w_state_nxt = COOL;
            COOL:    if (r_cool == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Aim at the kid's centre; ties leave the table sign untouched.
    assign w_negx  = ({1'b0, r_kx} + 11'(KID_SIZE / 2)) > {1'b0, r_bx};
    assign w_negy  = ({1'b0, r_ky} + 11'(KID_SIZE / 2)) > {1'b0, r_by};
    assign w_lanes = {1'b0, lane_count(r_pat)};

    // A slot freeing on this edge counts as free, so it can be re-used at once.
    always_comb begin
        w_spawn = '0;
        w_n     = '0;
        w_free  = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            w_lane[i] = '0;
            if (!w_keep[i]) begin
                w_free = w_free + 5'd1;
                if (r_state == SPAWN && w_n < w_lanes) begin
                    w_spawn[i] = 1'b1;
                    w_lane[i]  = w_n[2:0];
                    w_n        = w_n + 5'd1;
                end
            end
        end
        w_short = (r_state == SPAWN) && (w_free < w_lanes);
    end

    always_comb begin
        vel_t v;
        for (int i = 0; i < NUM_BALLS; i++) begin
            v = vel(r_pat, w_lane[i]);
            w_sdx[i] = (w_negx && r_pat != RING8) ? -v.dx : v.dx;
            w_sdy[i] = (w_negy && r_pat != RING8) ? -v.dy : v.dy;
        end
    end

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_slot
        ball_slot #(
            .LIFETIME(LIFETIME), .RADIUS(RADIUS), .KID_SIZE(KID_SIZE),
            .KILL_ON_HIT(KILL_ON_HIT), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset_n   (Reset_n),
            .i_spawn   (w_spawn[g]),
            .i_spawn_x (r_bx),
            .i_spawn_y (r_by),
            .i_dx      (w_sdx[g]),
            .i_dy      (w_sdy[g]),
            .i_kid_x   (bus.Kid_position_X),
            .i_kid_y   (bus.Kid_position_Y),
            .i_draw_x  (bus.DrawX),
            .i_draw_y  (bus.DrawY),
            .o_keep    (w_keep[g]),
            .o_covers  (w_covers[g]),
            .o_hit     (w_hit[g])
        );
    end

    always_comb begin
        w_id = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--)
            if (w_covers[i]) w_id = IDW'(i);
    end

    // Count what will be alive after this edge so the registered count
    // always matches the slots' current state.
    always_comb begin
        w_active_nxt = '0;
        for (int i = 0; i < NUM_BALLS; i++)
            w_active_nxt = w_active_nxt + CW'(w_keep[i] | w_spawn[i]);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hit     <= 1'b0;
            r_dropped <= 1'b0;
            r_active  <= '0;
        end else begin
            r_hit     <= |w_hit;
            r_dropped <= w_short;
            r_active  <= w_active_nxt;
        end
    end

    assign bus.isBall       = |w_covers;
    assign bus.ball_id      = w_id;
    assign bus.hitBall      = r_hit;
    assign bus.ready        = (r_state == IDLE);
    assign bus.active_count = r_active;
    assign bus.dropped      = r_dropped;
endmodule

// File: tb/tb_ball_pool.sv
module tb_ball_pool;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #50 clk = ~clk;

    ball_if #(.NUM_BALLS(8)) bus ();

    ball_pool #(.NUM_BALLS(8)) dut (
        .frame_clk (clk),
        .Reset_n   (rst_n),
        .bus       (bus.slave)
    );

    typedef struct {
        int x;
        int y;
        int is_ball;
        int id;
    } rv_t;

    rv_t rtab [10];
    int  vec_cnt = 0;
    int  miss    = 0;
    int  e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepn(input int n);
        repeat (n) step();
    endtask

    task automatic draw(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        #2;
    endtask

    task automatic setup(input int pat, input int bx, input int by, input int kx, input int ky);
        bus.pattern         = 2'(pat);
        bus.Boss_position_X = 10'(bx);
        bus.Boss_position_Y = 10'(by);
        bus.Kid_position_X  = 10'(kx);
        bus.Kid_position_Y  = 10'(ky);
        bus.fire            = 1'b1;
    endtask

    initial begin
        // Pool state right after the second FAN5 volley (3 of 5 lanes land
        // on slots 5..7 at the boss point; slots 0..4 have moved 62 frames).
        rtab[0] = '{320, 400, 1, 5};
        rtab[1] = '{320, 338, 1, 0};
        rtab[2] = '{258, 338, 1, 1};
        rtab[3] = '{382, 338, 1, 2};
        rtab[4] = '{382, 400, 1, 4};
        rtab[5] = '{258, 410, 1, 3};
        rtab[6] = '{269, 400, 0, 0};
        rtab[7] = '{327, 407, 1, 5};
        rtab[8] = '{328, 407, 0, 0};
        rtab[9] = '{100, 100, 0, 0};

        bus.fire = 1'b0;
        bus.pattern = 2'd0;
        bus.Boss_position_X = '0;
        bus.Boss_position_Y = '0;
        bus.Kid_position_X = '0;
        bus.Kid_position_Y = '0;
        bus.DrawX = 10'd1000;
        bus.DrawY = 10'd1000;

        #20;
        check("rst_ready", bus.ready, 1);
        check("rst_active", bus.active_count, 0);
        check("rst_hit", bus.hitBall, 0);
        check("rst_dropped", bus.dropped, 0);
        check("rst_isball", bus.isBall, 0);
        check("rst_id", bus.ball_id, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // SINGLE aimed at a kid to the lower right: motion (+4,+10)
        setup(2, 320, 100, 400, 300);
        step();
        bus.fire = 1'b0;
        check("t1_ready_e1", bus.ready, 0);
        check("t1_active_e1", bus.active_count, 0);
        step();
        check("t1_active_e2", bus.active_count, 1);
        draw(320, 100); check("t1_cov_ctr", bus.isBall, 1); check("t1_id", bus.ball_id, 0);
        draw(330, 100); check("t1_cov_edge", bus.isBall, 1);
        draw(331, 100); check("t1_cov_out", bus.isBall, 0);
        step();
        draw(324, 110); check("t1_moved", bus.isBall, 1);
        draw(320, 100); check("t1_left_old", bus.isBall, 0);
        check("t1_active_e3", bus.active_count, 1);
        e = 3;
        while (bus.ready !== 1'b1 && e < 200) begin
            step();
            e++;
        end
        check("t1_ready_edge", e, 62);
        check("t1_active_end", bus.active_count, 0);
        check("t1_hit_end", bus.hitBall, 0);

        // FAN5 with fire held: second volley only after cooldown, partially dropped
        setup(0, 320, 400, 0, 0);
        step();
        step();
        check("t2_active_f2", bus.active_count, 5);
        check("t2_ready_f2", bus.ready, 0);
        stepn(60);
        check("t2_ready_f62", bus.ready, 1);
        check("t2_active_f62", bus.active_count, 5);
        step();
        check("t2_ready_f63", bus.ready, 0);
        bus.fire = 1'b0;
        step();
        check("t2_active_f64", bus.active_count, 8);
        check("t2_dropped_f64", bus.dropped, 1);
        for (int i = 0; i < 10; i++) begin
            draw(rtab[i].x, rtab[i].y);
            check($sformatf("t2_render%0d_is", i), bus.isBall, rtab[i].is_ball);
            check($sformatf("t2_render%0d_id", i), bus.ball_id, rtab[i].id);
        end
        step();
        check("t2_dropped_f65", bus.dropped, 0);
        stepn(236);
        check("t2_active_f301", bus.active_count, 8);
        step();
        check("t2_active_f302", bus.active_count, 3);
        stepn(61);
        check("t2_active_f363", bus.active_count, 3);
        step();
        check("t2_active_f364", bus.active_count, 0);

        // RING8 fills the pool; fire in COOL ignored; FAN5 then drops everything
        setup(1, 320, 240, 0, 0);
        step();
        bus.fire = 1'b0;
        step();
        check("t3_active_g2", bus.active_count, 8);
        stepn(8);
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        check("t3_cool_ready", bus.ready, 0);
        check("t3_cool_dropped", bus.dropped, 0);
        stepn(50);
        check("t3_ready_g61", bus.ready, 0);
        step();
        check("t3_ready_g62", bus.ready, 1);
        step();
        check("t3_not_queued", bus.ready, 1);
        check("t3_active_g63", bus.active_count, 8);
        bus.pattern = 2'd0;
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        check("t3_ready_g64", bus.ready, 0);
        step();
        check("t3_dropped_g65", bus.dropped, 1);
        check("t3_active_g65", bus.active_count, 8);
        step();
        check("t3_dropped_g66", bus.dropped, 0);
        check("t3_active_g66", bus.active_count, 8);
        draw(384, 240); check("t3_ring0", bus.isBall, 1); check("t3_ring0_id", bus.ball_id, 0);
        draw(320, 304); check("t3_ring2", bus.isBall, 1); check("t3_ring2_id", bus.ball_id, 2);

        // Asynchronous reset in the middle of COOL
        draw(384, 240);
        #10;
        rst_n = 1'b0;
        #1;
        check("rst2_ready", bus.ready, 1);
        check("rst2_active", bus.active_count, 0);
        check("rst2_dropped", bus.dropped, 0);
        check("rst2_hit", bus.hitBall, 0);
        check("rst2_isball", bus.isBall, 0);
        check("rst2_id", bus.ball_id, 0);
        #2;
        rst_n = 1'b1;

        // Kid at the spawn point: hit one frame later, killed on the same edge
        setup(2, 200, 200, 184, 184);
        step();
        bus.fire = 1'b0;
        step();
        check("t4_active_k2", bus.active_count, 1);
        check("t4_hit_k2", bus.hitBall, 0);
        step();
        check("t4_hit_k3", bus.hitBall, 1);
        check("t4_active_k3", bus.active_count, 0);
        step();
        check("t4_hit_k4", bus.hitBall, 0);

        // Left-edge cull: (20,200) with (-4,-10) reaches X=0 then culls
        e = 0;
        while (bus.ready !== 1'b1 && e < 200) begin
            step();
            e++;
        end
        check("t5_ready", bus.ready, 1);
        setup(2, 20, 200, 0, 0);
        step();
        bus.fire = 1'b0;
        step();
        check("t5_active_l2", bus.active_count, 1);
        draw(20, 200); check("t5_spawn_cov", bus.isBall, 1);
        stepn(5);
        check("t5_active_l7", bus.active_count, 1);
        draw(0, 150); check("t5_at_edge", bus.isBall, 1);
        step();
        check("t5_active_l8", bus.active_count, 0);
        draw(0, 150); check("t5_culled", bus.isBall, 0);
        draw(636, 150); check("t5_no_wrap", bus.isBall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end
endmodule
